// File: rtl/sm_init_loader_pkg.sv
// Shared state encoding, register map and helpers for sm_init_loader.
// SM_UPPER_TRI_EN switches the matrix beat count to the packed upper triangle.
package sm_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SIG_STREAM,
      ST_MAT_STREAM,
      ST_ARMED,
      ST_RUN
   } state_t;

   localparam logic [2:0] ADDR_CTRL = 3'd0;
   localparam logic [2:0] ADDR_BETA = 3'd1;
   localparam logic [2:0] ADDR_SIG  = 3'd2;
   localparam logic [2:0] ADDR_TSEL = 3'd3;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_START = 1;
   localparam int CTRL_CLR   = 2;

   function automatic int mat_beats(input int nb);
`ifdef SM_UPPER_TRI_EN
      return nb * (nb + 1) / 2;
`else
      return nb * nb;
`endif
   endfunction

endpackage

// File: rtl/sm_diag_gen.sv
// Streams the beta*I initial matrix row-major with a valid/ready handshake.
// SM_UPPER_TRI_EN restricts the walk to elements with col >= row.
module sm_diag_gen #(
   parameter int DATA_W    = 48,
   parameter int NUM_BANDS = 126
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              start,
   input  logic [DATA_W-1:0] beta,
   input  logic              tready,
   output logic [DATA_W-1:0] tdata,
   output logic              tvalid,
   output logic              tlast,
   output logic              done
);
   localparam int BW = $clog2(NUM_BANDS);

   logic [BW-1:0] row_q, col_q, nrow, ncol;
   logic          xfer;

   assign xfer = tvalid && tready;
   assign done = xfer && tlast;

   always_comb begin
      nrow = row_q;
      ncol = col_q + 1'b1;
      if (col_q == BW'(NUM_BANDS - 1)) begin
         nrow = row_q + 1'b1;
`ifdef SM_UPPER_TRI_EN
         ncol = row_q + 1'b1;
`else
         ncol = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         row_q  <= '0;
         col_q  <= '0;
         tdata  <= '0;
         tvalid <= 1'b0;
         tlast  <= 1'b0;
      end else if (start) begin
         row_q  <= '0;
         col_q  <= '0;
         tdata  <= beta;
         tvalid <= 1'b1;
         tlast  <= 1'b0;
      end else if (xfer) begin
         if (tlast) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
         end else begin
            // Next element is computed ahead so data is already registered when offered.
            row_q <= nrow;
            col_q <= ncol;
            tdata <= (nrow == ncol) ? beta : '0;
            tlast <= (nrow == BW'(NUM_BANDS - 1)) && (ncol == BW'(NUM_BANDS - 1));
         end
      end
   end

endmodule

// File: rtl/sm_init_loader.sv
// Config front end for the Sherman-Morrison core: buffers target signatures,
// streams them, then self-generates beta*I. SM_UPPER_TRI_EN: packed upper-triangle matrix.
module sm_init_loader
   import sm_loader_pkg::*;
#(
   parameter int PIXEL_DATA_WIDTH       = 16,
   parameter int CORRELATION_DATA_WIDTH = 48,
   parameter int NUM_BANDS              = 126,
   parameter int NUM_TARGETS            = 4
) (
   input  logic                                                  CLK,
   input  logic                                                  RESET,
   input  logic                                                  CFG_WR_EN,
   input  logic [2:0]                                            CFG_WR_ADDR,
   input  logic [63:0]                                           CFG_WR_DATA,
   output logic                                                  CFG_BUSY,
   output logic                                                  CFG_ERR,
   output logic [PIXEL_DATA_WIDTH-1:0]                           SIG_TDATA,
   output logic [((NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1)-1:0] SIG_TDEST,
   output logic                                                  SIG_TVALID,
   input  logic                                                  SIG_TREADY,
   output logic                                                  SIG_TLAST,
   output logic [CORRELATION_DATA_WIDTH-1:0]                     MAT_TDATA,
   output logic                                                  MAT_TVALID,
   input  logic                                                  MAT_TREADY,
   output logic                                                  MAT_TLAST,
   output logic                                                  CORE_ENABLE
);
   localparam int TDW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   localparam int BW  = $clog2(NUM_BANDS);
   localparam int PW  = $clog2(NUM_BANDS + 1);

   logic [PIXEL_DATA_WIDTH-1:0]       sig_mem [NUM_TARGETS][NUM_BANDS];
   state_t                            state_q;
   logic [CORRELATION_DATA_WIDTH-1:0] beta_q;
   logic [TDW-1:0]                    tsel_q, sig_tgt_q, nxt_tgt;
   logic [PW-1:0]                     ptr_q;
   logic [NUM_TARGETS-1:0][PW-1:0]    cnt_q;
   logic [BW-1:0]                     sig_band_q, nxt_band;
   logic                              en_q;
   logic wr_ctrl, wr_beta, wr_sig, wr_tsel, clr, start, sel_ok, sig_we, drop;
   logic all_loaded, sig_xfer, sig_last_band, sig_last_beat, mat_start, mat_done;
   logic unused_wr;

   assign wr_ctrl   = CFG_WR_EN && (CFG_WR_ADDR == ADDR_CTRL);
   assign wr_beta   = CFG_WR_EN && (CFG_WR_ADDR == ADDR_BETA);
   assign wr_sig    = CFG_WR_EN && (CFG_WR_ADDR == ADDR_SIG);
   assign wr_tsel   = CFG_WR_EN && (CFG_WR_ADDR == ADDR_TSEL);
   assign clr       = wr_ctrl && CFG_WR_DATA[CTRL_CLR];
   assign start     = wr_ctrl && CFG_WR_DATA[CTRL_START];
   assign sel_ok    = int'(tsel_q) < NUM_TARGETS;
   assign sig_we    = wr_sig && !CFG_BUSY && sel_ok && (ptr_q != PW'(NUM_BANDS));
   assign drop      = ((wr_sig || wr_tsel || wr_beta) && CFG_BUSY) || (wr_sig && !CFG_BUSY && !sig_we);
   assign unused_wr = &{1'b0, CFG_WR_DATA};

   always_comb begin
      all_loaded = 1'b1;
      for (int t = 0; t < NUM_TARGETS; t++)
         if (cnt_q[t] != PW'(NUM_BANDS)) all_loaded = 1'b0;
   end

   // Next-beat indices let the buffer read issue in the handshake cycle (prefetch).
   assign sig_xfer      = SIG_TVALID && SIG_TREADY;
   assign sig_last_band = (sig_band_q == BW'(NUM_BANDS - 1));
   assign sig_last_beat = sig_last_band && (sig_tgt_q == TDW'(NUM_TARGETS - 1));
   assign nxt_band      = sig_last_band ? '0 : sig_band_q + 1'b1;
   assign nxt_tgt       = sig_last_band ? sig_tgt_q + 1'b1 : sig_tgt_q;
   assign mat_start     = (state_q == ST_SIG_STREAM) && sig_xfer && sig_last_beat;

   always_ff @(posedge CLK)
      if (sig_we) sig_mem[tsel_q][ptr_q[BW-1:0]] <= CFG_WR_DATA[PIXEL_DATA_WIDTH-1:0];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         beta_q      <= '0;
         tsel_q      <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         en_q        <= 1'b0;
         CFG_BUSY    <= 1'b0;
         CFG_ERR     <= 1'b0;
         SIG_TDATA   <= '0;
         SIG_TDEST   <= '0;
         SIG_TVALID  <= 1'b0;
         SIG_TLAST   <= 1'b0;
         sig_tgt_q   <= '0;
         sig_band_q  <= '0;
         CORE_ENABLE <= 1'b0;
      end else if (clr) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         en_q        <= 1'b0;
         CFG_BUSY    <= 1'b0;
         CFG_ERR     <= 1'b0;
         SIG_TVALID  <= 1'b0;
         SIG_TLAST   <= 1'b0;
         CORE_ENABLE <= 1'b0;
      end else begin
         if (wr_ctrl) en_q <= CFG_WR_DATA[CTRL_EN];
         if (drop) CFG_ERR <= 1'b1;
         if (wr_beta && !CFG_BUSY) beta_q <= CFG_WR_DATA[CORRELATION_DATA_WIDTH-1:0];
         if (wr_tsel && !CFG_BUSY) begin
            tsel_q <= CFG_WR_DATA[TDW-1:0];
            ptr_q  <= '0;
         end
         if (sig_we) begin
            ptr_q         <= ptr_q + 1'b1;
            cnt_q[tsel_q] <= ptr_q + 1'b1;
         end
         case (state_q)
            ST_IDLE: if (start) begin
               if (all_loaded) begin
                  state_q    <= ST_SIG_STREAM;
                  CFG_BUSY   <= 1'b1;
                  SIG_TVALID <= 1'b1;
                  SIG_TDATA  <= sig_mem[0][0];
                  SIG_TDEST  <= '0;
                  SIG_TLAST  <= (NUM_BANDS == 1);
                  sig_tgt_q  <= '0;
                  sig_band_q <= '0;
               end else begin
                  CFG_ERR <= 1'b1;
               end
            end
            ST_SIG_STREAM: if (sig_xfer) begin
               if (sig_last_beat) begin
                  state_q    <= ST_MAT_STREAM;
                  SIG_TVALID <= 1'b0;
                  SIG_TLAST  <= 1'b0;
               end else begin
                  sig_tgt_q  <= nxt_tgt;
                  sig_band_q <= nxt_band;
                  SIG_TDATA  <= sig_mem[nxt_tgt][nxt_band];
                  SIG_TDEST  <= nxt_tgt;
                  SIG_TLAST  <= (nxt_band == BW'(NUM_BANDS - 1));
               end
            end
            ST_MAT_STREAM: if (mat_done) begin
               state_q  <= ST_ARMED;
               CFG_BUSY <= 1'b0;
            end
            ST_ARMED: if (en_q) begin
               state_q     <= ST_RUN;
               CORE_ENABLE <= 1'b1;
            end
            ST_RUN: if (!en_q) begin
               state_q     <= ST_ARMED;
               CORE_ENABLE <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   sm_diag_gen #(
      .DATA_W   (CORRELATION_DATA_WIDTH),
      .NUM_BANDS(NUM_BANDS)
   ) u_diag (
      .clk   (CLK),
      .rst   (RESET),
      .clr   (clr),
      .start (mat_start),
      .beta  (beta_q),
      .tready(MAT_TREADY),
      .tdata (MAT_TDATA),
      .tvalid(MAT_TVALID),
      .tlast (MAT_TLAST),
      .done  (mat_done)
   );

endmodule
